uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 128 ++++++++++++
 tb/tb_uart_cmd_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns bytes from a UART receiver into switch toggles,
// timed button pulses and a clear-all command, with ack/err status pulses.
//
// Byte handshake: new_data is a level with no back-pressure. A byte is taken
// on the clk edge where new_data is 1 and was 0 at the previous edge; holding
// new_data high never repeats the command. ascii_code must be stable while
// new_data is high. new_data_q resets to 1, so a new_data level that is
// already high when reset releases is ignored until it falls and rises again.
`timescale 1ns/1ps
module uart_cmd_decoder #(
   parameter int N_SWITCHES   = 12,
   parameter int N_BUTTONS    = 4,
   parameter int SW_BASE      = 33,
   parameter int BTN_BASE     = SW_BASE + N_SWITCHES,
   parameter int PULSE_CYCLES = 1000,
   parameter int CLR_CODE     = 126
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_data,
   input  logic [7:0]            ascii_code,
   output logic [N_SWITCHES-1:0] switches,
   output logic [N_BUTTONS-1:0]  buttons,
   output logic                  cmd_ack,
   output logic                  cmd_err
);

   localparam int CW       = $clog2(PULSE_CYCLES + 1);
   localparam int SW_LAST  = SW_BASE + N_SWITCHES - 1;
   localparam int BTN_LAST = BTN_BASE + N_BUTTONS - 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Reject parameter sets whose code ranges collide or leave the byte space.
   if (N_SWITCHES < 1 || N_SWITCHES > 64) begin : g_bad_n_switches
      $error("uart_cmd_decoder: N_SWITCHES must be 1..64");
   end
   if (N_BUTTONS < 1 || N_BUTTONS > 16) begin : g_bad_n_buttons
      $error("uart_cmd_decoder: N_BUTTONS must be 1..16");
   end
   if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("uart_cmd_decoder: PULSE_CYCLES must be >= 1");
   end
   if (SW_BASE < 0 || SW_LAST > 255 || BTN_BASE < 0 || BTN_LAST > 255) begin : g_bad_range
      $error("uart_cmd_decoder: switch/button codes must lie in 0..255");
   end
   if (SW_BASE <= BTN_LAST && BTN_BASE <= SW_LAST) begin : g_overlap
      $error("uart_cmd_decoder: switch and button code ranges overlap");
   end
   if ((CLR_CODE >= SW_BASE && CLR_CODE <= SW_LAST) ||
       (CLR_CODE >= BTN_BASE && CLR_CODE <= BTN_LAST)) begin : g_clr_clash
      $error("uart_cmd_decoder: CLR_CODE falls inside a switch/button range");
   end

   logic                  new_data_q;
   logic                  accept;
   int                    code_i;
   logic [N_SWITCHES-1:0] sw_hit;
   logic [N_BUTTONS-1:0]  btn_hit;
   logic                  clr_hit;
   logic                  known;
   logic [CW-1:0]         cnt [N_BUTTONS];

   assign accept = new_data & ~new_data_q;
   assign code_i = {24'd0, ascii_code};

   // Decode the received byte into one-hot switch/button hits and clear.
   always_comb begin
      sw_hit  = '0;
      btn_hit = '0;
      for (int i = 0; i < N_SWITCHES; i++) begin
         sw_hit[i] = (code_i == SW_BASE + i);
      end
      for (int j = 0; j < N_BUTTONS; j++) begin
         btn_hit[j] = (code_i == BTN_BASE + j);
      end
      clr_hit = (code_i == CLR_CODE);
      known   = (|sw_hit) | (|btn_hit) | clr_hit;
   end

   // Previous new_data level for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) new_data_q <= 1'b1;
      else       new_data_q <= new_data;
   end

   // Toggle the addressed switch, or clear every switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  switches <= '0;
      else if (accept && clr_hit) switches <= '0;
      else if (accept)            switches <= switches ^ sw_hit;
   end

   // Per-button down-counters: load on press, drop the output when they expire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buttons <= '0;
         for (int j = 0; j < N_BUTTONS; j++) cnt[j] <= '0;
      end else begin
         for (int j = 0; j < N_BUTTONS; j++) begin
            if (accept && clr_hit) begin
               cnt[j]     <= '0;
               buttons[j] <= 1'b0;
            end else if (accept && btn_hit[j]) begin
               cnt[j]     <= CNT_LOAD;
               buttons[j] <= 1'b1;
            end else if (cnt[j] == CNT_ONE) begin
               cnt[j]     <= '0;
               buttons[j] <= 1'b0;
            end else if (cnt[j] != '0) begin
               cnt[j]     <= cnt[j] - CNT_ONE;
            end
         end
      end
   end

   // One-cycle status pulse following every accepted byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ack <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         cmd_ack <= accept & known;
         cmd_err <= accept & ~known;
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed scenarios plus random byte traffic, checked
// cycle by cycle against a behavioural model of the command decoder.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
  localparam int NSW = 12;
  localparam int NB  = 4;
  localparam int PC  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic new_data = 1'b0;
  logic [7:0] ascii_code = 8'd0;
  logic [NSW-1:0] switches;
  logic [NB-1:0] buttons;
  logic cmd_ack, cmd_err;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .new_data(new_data), .ascii_code(ascii_code),
    .switches(switches), .buttons(buttons), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Switch state as a bit vector, each button as "cycles of high left".
  logic [NSW-1:0] m_sw = '0;
  int m_rem [NB];
  logic m_ack = 1'b0, m_err = 1'b0, m_prev_nd = 1'b1, m_acc;
  int m_c;
  logic [NB-1:0] m_btn;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sw = '0; m_ack = 1'b0; m_err = 1'b0; m_prev_nd = 1'b1;
      for (int j = 0; j < NB; j++) m_rem[j] = 0;
    end else begin
      m_acc = new_data && !m_prev_nd;
      m_prev_nd = new_data;
      m_ack = 1'b0; m_err = 1'b0;
      for (int j = 0; j < NB; j++) if (m_rem[j] > 0) m_rem[j] = m_rem[j] - 1;
      if (m_acc) begin
        m_c = ascii_code;
        if (m_c >= 33 && m_c <= 44) begin
          m_sw[m_c - 33] = ~m_sw[m_c - 33];
          m_ack = 1'b1;
        end else if (m_c >= 45 && m_c <= 48) begin
          m_rem[m_c - 45] = PC;
          m_ack = 1'b1;
        end else if (m_c == 126) begin
          m_sw = '0;
          for (int j = 0; j < NB; j++) m_rem[j] = 0;
          m_ack = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare + pulse statistics ----------------
  int ack_cnt = 0, err_cnt = 0, both13_cnt = 0;
  int hi_cnt [NB];
  int rise_cnt [NB];
  logic [NB-1:0] btn_prev = '0;

  always @(posedge clk) begin
    #1;
    for (int j = 0; j < NB; j++) m_btn[j] = (m_rem[j] > 0);
    check("switches", switches, m_sw);
    check("buttons", buttons, m_btn);
    check("cmd_ack", cmd_ack, m_ack);
    check("cmd_err", cmd_err, m_err);
    if (cmd_ack) ack_cnt++;
    if (cmd_err) err_cnt++;
    if (buttons[1] && buttons[3]) both13_cnt++;
    for (int j = 0; j < NB; j++) begin
      if (buttons[j]) hi_cnt[j]++;
      if (buttons[j] && !btn_prev[j]) rise_cnt[j]++;
    end
    btn_prev = buttons;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    ack_cnt = 0; err_cnt = 0; both13_cnt = 0;
    for (int j = 0; j < NB; j++) begin hi_cnt[j] = 0; rise_cnt[j] = 0; end
  endtask

  // Called at a falling edge; leaves at a falling edge.
  task automatic send(input logic [7:0] code, input int hold, input int gap);
    ascii_code = code;
    new_data = 1'b1;
    repeat (hold) @(negedge clk);
    new_data = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int j = 0; j < NB; j++) begin m_rem[j] = 0; hi_cnt[j] = 0; rise_cnt[j] = 0; end
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_switches", switches, 0);
    check("rst_buttons", buttons, 0);
    check("rst_ack_err", {cmd_ack, cmd_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Two switch codes toggle the end switches.
    clear_stats();
    send(8'd33, 1, 1);
    send(8'd44, 1, 1);
    check("s1_switches", switches, 12'h801);
    check("s1_acks", ack_cnt, 2);
    check("s1_errs", err_cnt, 0);

    // Repeated code toggles back; a long new_data level is one command.
    send(8'd33, 1, 1);
    check("s2_toggle_off", switches, 12'h800);
    send(8'd33, 1, 1);
    send(8'd33, 10, 1);
    check("s2_held_once", switches, 12'h800);

    // Single button pulse, then a retriggered pulse.
    clear_stats();
    send(8'd45, 1, 6);
    check("s3_pulse_len", hi_cnt[0], PC);
    check("s3_pulse_rises", rise_cnt[0], 1);
    clear_stats();
    send(8'd45, 1, 1);
    send(8'd45, 1, 8);
    check("s3_retrig_len", hi_cnt[0], 6);
    check("s3_retrig_rises", rise_cnt[0], 1);

    // Overlapping independent buttons.
    clear_stats();
    send(8'd46, 1, 1);
    send(8'd48, 1, 8);
    check("s4_btn1_len", hi_cnt[1], PC);
    check("s4_btn3_len", hi_cnt[3], PC);
    check("s4_overlap", both13_cnt, 2);

    // Unknown code, then clear with everything set.
    clear_stats();
    send(8'd65, 1, 2);
    check("s5_err", err_cnt, 1);
    check("s5_no_ack", ack_cnt, 0);
    check("s5_unchanged", switches, 12'h800);
    send(8'd126, 1, 1);
    for (int i = 0; i < NSW; i++) send(8'(33 + i), 1, 1);
    check("s5_all_on", switches, 12'hFFF);
    send(8'd45, 1, 1);
    check("s5_btn_on", buttons, 4'b0001);
    clear_stats();
    send(8'd126, 1, 1);
    check("s5_clr_sw", switches, 0);
    check("s5_clr_btn", buttons, 0);
    check("s5_clr_ack", ack_cnt, 1);

    // Reset mid-pulse with new_data still high across release.
    ascii_code = 8'd47;
    new_data = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s6_btn_before", buttons, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_btn", buttons, 0);
    check("s6_rst_ack", cmd_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("s6_no_cmd", ack_cnt, 0);
    check("s6_no_pulse", hi_cnt[2], 0);
    new_data = 1'b0;
    @(negedge clk);
    send(8'd33, 1, 1);
    check("s6_after", switches, 12'h001);
    check("s6_after_ack", ack_cnt, 1);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] code;
      case ($urandom_range(0, 3))
        0: code = 8'($urandom_range(33, 44));
        1: code = 8'($urandom_range(45, 48));
        2: code = ($urandom_range(0, 5) == 0) ? 8'd126 : 8'($urandom_range(0, 255));
        default: code = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      send(code, $urandom_range(1, 3), $urandom_range(1, 3));
    end
    repeat (PC + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
